// File: rtl/memory_interface_pkg.sv
// Shared definitions for the memory_interface block: FSM state encoding,
// default geometry and the wait-state counter width.
package memory_interface_pkg;

  // Default geometry: 512 words of 32 bits.
  localparam int ADDR_W_DEFAULT = 9;
  localparam int DATA_W_DEFAULT = 32;

  // Wait-state counter width; covers WAIT_CYCLES of 0..15.
  localparam int WAIT_W = 4;

  // Access sequencer states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage : memory_interface_pkg

// File: rtl/memory_interface_ram.sv
// ram_512x32: single-port synchronous array. Writes and reads both occur on
// the rising clock edge; dout is the registered contents at addr.
// With MEM_PARITY_EN defined each word carries one extra parity bit.
module ram_512x32
  import memory_interface_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic                                clock,
  input  logic                                we,
  input  logic [ADDR_W-1:0]                   addr,
`ifdef MEM_PARITY_EN
  input  logic [DATA_W:0]                     din,
  output logic [DATA_W:0]                     dout
`else
  input  logic [DATA_W-1:0]                   din,
  output logic [DATA_W-1:0]                   dout
`endif
);

`ifdef MEM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  localparam int DEPTH = 1 << ADDR_W;

  logic [MEM_W-1:0] mem [DEPTH];

  // Synchronous write and registered read of the addressed word.
  // NOTE: the array has no reset; clearing every word would turn the storage
  // into flops and its contents are undefined until written anyway.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= din;
    end
    dout <= mem[addr];
  end

endmodule : ram_512x32

// File: rtl/memory_interface.sv
// memory_interface: word-addressed memory behind the MAR/MDR pair.
// Accepts level Read/Write requests, inserts WAIT_CYCLES wait states,
// performs the access on ram_512x32 and signals completion on MFC, which
// stays high until the requester drops its request.
// Optional feature macro: MEM_PARITY_EN (even parity per word, err output).
module memory_interface
  import memory_interface_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEFAULT,
  parameter int DATA_W      = DATA_W_DEFAULT,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              Read,
  input  logic              Write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] Mdatain,
  output logic              MFC,
  output logic              busy,
  output logic              err
);

`ifdef MEM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  state_t              state;
  logic [WAIT_W-1:0]   cnt;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                op_write;

  logic                ram_we;
  logic [ADDR_W-1:0]   ram_addr;
  logic [MEM_W-1:0]    ram_din;
  logic [MEM_W-1:0]    ram_dout;

  // Final ACCESS edge: the array operation happens here and nowhere else,
  // so a reset earlier in ACCESS keeps a pending write out of the array.
  logic                fire;
  assign fire = (state == ACCESS) && (cnt == '0);

  // Request the originating operation is waiting on while in DONE.
  logic                req_held;
  assign req_held = op_write ? Write : Read;

  // Array port control. In IDLE the array is addressed by the live addr so
  // that the word of an accepted access is registered on the accept edge;
  // afterwards it follows the latched address.
  // NOTE: every output gets a default first so no path leaves a latch.
  always_comb begin
    ram_we   = 1'b0;
    ram_addr = addr_q;
    if (state == IDLE) begin
      ram_addr = addr;
    end
    if (fire && op_write) begin
      ram_we = 1'b1;
    end
  end

`ifdef MEM_PARITY_EN
  // Even parity: the stored word including the parity bit has an even number of ones.
  assign ram_din = {^wdata_q, wdata_q};
`else
  assign ram_din = wdata_q;
`endif

  ram_512x32 #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clock (clock),
    .we    (ram_we),
    .addr  (ram_addr),
    .din   (ram_din),
    .dout  (ram_dout)
  );

  // Access sequencer: latch request, count wait states, complete, handshake.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state    <= IDLE;
      cnt      <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      op_write <= 1'b0;
      Mdatain  <= '0;
      MFC      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Read || Write) begin
            addr_q   <= addr;
            wdata_q  <= wdata;
            op_write <= Write;   // Write wins when both are high
            cnt      <= WAIT_W'(WAIT_CYCLES);
            busy     <= 1'b1;
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt != '0) begin
            cnt <= cnt - WAIT_W'(1);
          end else begin
            if (!op_write) begin
              Mdatain <= ram_dout[DATA_W-1:0];
            end
            MFC   <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          if (!req_held) begin
            MFC   <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef MEM_PARITY_EN
  logic err_q;

  // Parity flag: set on read completion, cleared when the next access is accepted.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      err_q <= 1'b0;
    end else if (state == IDLE && (Read || Write)) begin
      err_q <= 1'b0;
    end else if (fire && !op_write) begin
      err_q <= ram_dout[DATA_W] ^ (^ram_dout[DATA_W-1:0]);
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule : memory_interface

// File: tb/tb_memory_interface.sv
// Directed testbench for memory_interface. Instance u_a runs with two wait
// states, u_b with none. Inputs change on the falling edge and outputs are
// sampled on the falling edge, half a cycle away from the active edge.
module tb_memory_interface;

  logic        clock = 1'b0;
  logic        clear;

  logic        rd_a, wr_a, rd_b, wr_b;
  logic [8:0]  addr_a, addr_b;
  logic [31:0] wdata_a, wdata_b;
  logic [31:0] mdatain_a, mdatain_b;
  logic        mfc_a, mfc_b, busy_a, busy_b, err_a, err_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  memory_interface #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(2)) u_a (
    .clock   (clock),
    .clear   (clear),
    .Read    (rd_a),
    .Write   (wr_a),
    .addr    (addr_a),
    .wdata   (wdata_a),
    .Mdatain (mdatain_a),
    .MFC     (mfc_a),
    .busy    (busy_a),
    .err     (err_a)
  );

  memory_interface #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(0)) u_b (
    .clock   (clock),
    .clear   (clear),
    .Read    (rd_b),
    .Write   (wr_b),
    .addr    (addr_b),
    .wdata   (wdata_b),
    .Mdatain (mdatain_b),
    .MFC     (mfc_b),
    .busy    (busy_b),
    .err     (err_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic mfc_of(input bit sel);
    return sel ? mfc_b : mfc_a;
  endfunction

  function automatic logic busy_of(input bit sel);
    return sel ? busy_b : busy_a;
  endfunction

  function automatic logic err_of(input bit sel);
    return sel ? err_b : err_a;
  endfunction

  function automatic logic [31:0] mdat_of(input bit sel);
    return sel ? mdatain_b : mdatain_a;
  endfunction

  task automatic drive(input bit sel, input logic rd, input logic wr,
                       input logic [8:0] a, input logic [31:0] d);
    if (sel) begin
      rd_b = rd; wr_b = wr; addr_b = a; wdata_b = d;
    end else begin
      rd_a = rd; wr_a = wr; addr_a = a; wdata_a = d;
    end
  endtask

  // One full request/handshake. Called on a falling edge; the request is
  // accepted at the next rising edge (e0). addr/wdata are scrambled right
  // after acceptance to show they are ignored mid-access. exp_mdat is the
  // required Mdatain at MFC (the unchanged old value for writes).
  task automatic xfer(input string tag, input bit sel, input logic rd, input logic wr,
                      input logic [8:0] a, input logic [31:0] d, input int lat_exp,
                      input int hold, input logic [31:0] exp_mdat, input logic exp_err);
    int n;
    int stable;
    logic [31:0] snap;
    drive(sel, rd, wr, a, d);
    @(negedge clock);
    check({tag, " busy after accept"}, 32'(busy_of(sel)), 32'd1);
    check({tag, " err after accept"}, 32'(err_of(sel)), 32'd0);
    drive(sel, rd, wr, ~a, ~d);
    n = 0;
    while (!mfc_of(sel) && n < 40) begin
      check({tag, " busy while waiting"}, 32'(busy_of(sel)), 32'd1);
      @(negedge clock);
      n++;
    end
    check({tag, " MFC latency"}, 32'(n), 32'(lat_exp));
    check({tag, " Mdatain at MFC"}, mdat_of(sel), exp_mdat);
    check({tag, " err at MFC"}, 32'(err_of(sel)), 32'(exp_err));
    snap   = mdat_of(sel);
    stable = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      if (mfc_of(sel) && busy_of(sel) && mdat_of(sel) === snap) stable++;
    end
    if (hold > 0) check({tag, " MFC held with request"}, 32'(stable), 32'(hold));
    drive(sel, 1'b0, 1'b0, ~a, ~d);
    @(negedge clock);
    check({tag, " MFC after drop"}, 32'(mfc_of(sel)), 32'd0);
    check({tag, " busy after drop"}, 32'(busy_of(sel)), 32'd0);
    check({tag, " Mdatain after drop"}, mdat_of(sel), exp_mdat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 9'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 9'h0, 32'h0);
    repeat (2) @(negedge clock);
    check("reset Mdatain", mdatain_a, 32'h0);
    check("reset MFC", 32'(mfc_a), 32'd0);
    check("reset busy", 32'(busy_a), 32'd0);
    check("reset err", 32'(err_a), 32'd0);
    clear = 1'b1;
    @(negedge clock);

    // --- two wait states ---
    xfer("wr 012", 1'b0, 1'b0, 1'b1, 9'h012, 32'hDEADBEEF, 3, 0, 32'h0, 1'b0);
    xfer("rd 012 hold", 1'b0, 1'b1, 1'b0, 9'h012, 32'h0, 3, 10, 32'hDEADBEEF, 1'b0);
    xfer("rd+wr 005", 1'b0, 1'b1, 1'b1, 9'h005, 32'h11111111, 3, 0, 32'hDEADBEEF, 1'b0);
    xfer("rd 005", 1'b0, 1'b1, 1'b0, 9'h005, 32'h0, 3, 0, 32'h11111111, 1'b0);
    xfer("preload 100", 1'b0, 1'b0, 1'b1, 9'h100, 32'h00000000, 3, 0, 32'h11111111, 1'b0);

    // Abort a write with reset while cnt=1 (after e1).
    drive(1'b0, 1'b0, 1'b1, 9'h100, 32'hCAFEF00D);
    @(negedge clock);
    @(negedge clock);
    clear = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 9'h100, 32'hCAFEF00D);
    #1;
    check("abort MFC", 32'(mfc_a), 32'd0);
    check("abort busy", 32'(busy_a), 32'd0);
    check("abort Mdatain", mdatain_a, 32'h0);
    check("abort err", 32'(err_a), 32'd0);
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    xfer("rd 100 after abort", 1'b0, 1'b1, 1'b0, 9'h100, 32'h0, 3, 0, 32'h00000000, 1'b0);

`ifdef MEM_PARITY_EN
    xfer("wr 020", 1'b0, 1'b0, 1'b1, 9'h020, 32'h0000000F, 3, 0, 32'h00000000, 1'b0);
    u_a.u_ram.mem[9'h020] = u_a.u_ram.mem[9'h020] ^ 33'h8;
    xfer("rd 020 parity", 1'b0, 1'b1, 1'b0, 9'h020, 32'h0, 3, 0, 32'h00000007, 1'b1);
    xfer("rd 012 clears err", 1'b0, 1'b1, 1'b0, 9'h012, 32'h0, 3, 0, 32'hDEADBEEF, 1'b0);
`endif

    // --- zero wait states, back-to-back at the top address ---
    xfer("b wr 1FF", 1'b1, 1'b0, 1'b1, 9'h1FF, 32'h13572468, 1, 0, 32'h0, 1'b0);
    xfer("b wr 000", 1'b1, 1'b0, 1'b1, 9'h000, 32'h55AA55AA, 1, 0, 32'h0, 1'b0);
    xfer("b rd 1FF", 1'b1, 1'b1, 1'b0, 9'h1FF, 32'h0, 1, 0, 32'h13572468, 1'b0);
    xfer("b wr 1FF again", 1'b1, 1'b0, 1'b1, 9'h1FF, 32'h2468ACE0, 1, 0, 32'h13572468, 1'b0);
    xfer("b rd 1FF again", 1'b1, 1'b1, 1'b0, 9'h1FF, 32'h0, 1, 0, 32'h2468ACE0, 1'b0);
    xfer("b rd 000", 1'b1, 1'b1, 1'b0, 9'h000, 32'h0, 1, 0, 32'h55AA55AA, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_memory_interface
